// File: rtl/mem_stage_unit.sv
// mem_stage_unit: memory-stage access controller turning loads/stores into a
// valid/ready data-memory request, stalling until complete, and producing the
// writeback feedback (mem_write/_reg/_data) for the EX/MEM register.
// Ports: clock/reset (async active-high); mem_* inputs from the EX/MEM register;
// mem_stall to the pipeline; d_req_* / d_resp_* data-memory port; mem_write*
// writeback outputs (registered, one cycle after the instruction presents).
module mem_stage_unit #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_load,
  input  logic                    mem_store,
  input  logic                    mem_regWrite,
  input  logic [DATA_WIDTH-1:0]   mem_ALU_result,
  input  logic [DATA_WIDTH-1:0]   mem_store_data,
  input  logic [4:0]              mem_rd,
  output logic                    mem_stall,
  output logic                    d_req_valid,
  input  logic                    d_req_ready,
  output logic                    d_req_write,
  output logic [ADDRESS_BITS-1:0] d_req_addr,
  output logic [DATA_WIDTH-1:0]   d_req_wdata,
  input  logic                    d_resp_valid,
  input  logic [DATA_WIDTH-1:0]   d_resp_data,
  output logic                    mem_write,
  output logic [4:0]              mem_write_reg,
  output logic [DATA_WIDTH-1:0]   mem_write_data
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state;
  logic       is_store;
  logic       rw_q;
  logic [4:0] rd_q;
  logic       mem_op;
  logic       unused_ok;
  // Upper address bits are truncated by design; CORE is identification only.
  assign unused_ok = ^{mem_ALU_result[DATA_WIDTH-1:ADDRESS_BITS], 1'(CORE)};
  assign mem_op = mem_load | mem_store;
  // Reset gates the stall so every output reads 0 while reset is held.
  assign mem_stall = !reset && ((state == IDLE && mem_op) || state == REQ || state == WAIT);
  assign d_req_valid = state == REQ;
  assign d_req_write = is_store;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      is_store       <= 1'b0;
      rw_q           <= 1'b0;
      rd_q           <= 5'd0;
      d_req_addr     <= '0;
      d_req_wdata    <= '0;
      mem_write      <= 1'b0;
      mem_write_reg  <= 5'd0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            // Load+store together is treated as a store with no writeback.
            is_store    <= mem_store;
            rw_q        <= mem_regWrite & !mem_store;
            rd_q        <= mem_rd;
            d_req_addr  <= mem_ALU_result[ADDRESS_BITS-1:0];
            d_req_wdata <= mem_store_data;
            mem_write   <= 1'b0;
            state       <= REQ;
          end else begin
            mem_write      <= mem_regWrite & (mem_rd != 5'd0);
            mem_write_reg  <= mem_rd;
            mem_write_data <= mem_ALU_result;
          end
        end
        REQ: if (d_req_ready) state <= is_store ? DONE : WAIT;
        WAIT: begin
          if (d_resp_valid) begin
            mem_write      <= rw_q & (rd_q != 5'd0);
            mem_write_reg  <= rd_q;
            mem_write_data <= d_resp_data;
            state          <= DONE;
          end
        end
        default: begin
          mem_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: directed self-checking bench for mem_stage_unit.
module tb_mem_stage_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_load, mem_store, mem_regWrite;
  logic [31:0] mem_ALU_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_stall, d_req_valid, d_req_ready, d_req_write;
  logic [19:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_write;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_write_data;
  int n_cmp = 0;
  int n_fail = 0;
  mem_stage_unit dut (
    .clock(clock), .reset(reset), .mem_load(mem_load), .mem_store(mem_store),
    .mem_regWrite(mem_regWrite), .mem_ALU_result(mem_ALU_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_stall(mem_stall),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_resp_valid(d_resp_valid),
    .d_resp_data(d_resp_data), .mem_write(mem_write), .mem_write_reg(mem_write_reg),
    .mem_write_data(mem_write_data)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic idle_in();
    mem_load = 0; mem_store = 0; mem_regWrite = 0; mem_ALU_result = 0;
    mem_store_data = 0; mem_rd = 0; d_req_ready = 0; d_resp_valid = 0; d_resp_data = 0;
  endtask
  task automatic step();
    @(posedge clock); #1;
  endtask
  task automatic test_reset();
    idle_in();
    reset = 1;
    step(); step();
    @(negedge clock);
    n_cmp++; if ({mem_stall, d_req_valid, d_req_write, mem_write} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {mem_stall, d_req_valid, d_req_write, mem_write}); end
    n_cmp++; if ({d_req_addr, d_req_wdata, mem_write_reg, mem_write_data} !== '0) begin n_fail++; $display("FAIL reset_data: got addr %h wdata %h reg %0d data %h expected all 0", d_req_addr, d_req_wdata, mem_write_reg, mem_write_data); end
    step(); reset = 0;
    mem_load = 1; mem_regWrite = 1; mem_rd = 6; mem_ALU_result = 32'h40;
    @(negedge clock);
    n_cmp++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %b expected 1", mem_stall); end
    step();
    @(negedge clock);
    n_cmp++; if (d_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", d_req_valid); end
    #1 reset = 1;
    #1;
    n_cmp++; if ({d_req_valid, mem_stall, mem_write} !== 3'b000) begin n_fail++; $display("FAIL rst_async: got valid/stall/write %b expected 000", {d_req_valid, mem_stall, mem_write}); end
    idle_in();
    step(); reset = 0;
    @(negedge clock);
    n_cmp++; if ({d_req_valid, mem_stall, mem_write} !== 3'b000) begin n_fail++; $display("FAIL rst_idle: got valid/stall/write %b expected 000", {d_req_valid, mem_stall, mem_write}); end
    step();
  endtask
  task automatic test_passthrough();
    mem_regWrite = 1; mem_rd = 5; mem_ALU_result = 32'h1234;
    @(negedge clock);
    n_cmp++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL pt_stall: got %b expected 0", mem_stall); end
    step();
    mem_regWrite = 1; mem_rd = 0; mem_ALU_result = 32'h55;
    @(negedge clock);
    n_cmp++; if ({mem_write, mem_write_reg, mem_write_data} !== {1'b1, 5'd5, 32'h1234}) begin n_fail++; $display("FAIL pt_wb: got %b/%0d/%h expected 1/5/00001234", mem_write, mem_write_reg, mem_write_data); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL pt_stall2: got %b expected 0", mem_stall); end
    step();
    idle_in();
    @(negedge clock);
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL pt_rd0: got %b expected 0", mem_write); end
    step();
  endtask
  task automatic test_store();
    mem_store = 1; mem_ALU_result = 32'h00000100; mem_store_data = 32'hDEADBEEF; d_req_ready = 0;
    @(negedge clock);
    n_cmp++; if ({mem_stall, d_req_valid} !== 2'b10) begin n_fail++; $display("FAIL st_idle: got stall/valid %b expected 10", {mem_stall, d_req_valid}); end
    for (int i = 0; i < 4; i++) begin
      step();
      d_req_ready = (i == 3);
      @(negedge clock);
      n_cmp++; if ({d_req_valid, d_req_write, mem_stall, mem_write} !== 4'b1110) begin n_fail++; $display("FAIL st_req%0d: got valid/write/stall/wb %b expected 1110", i, {d_req_valid, d_req_write, mem_stall, mem_write}); end
      n_cmp++; if ({d_req_addr, d_req_wdata} !== {20'h00100, 32'hDEADBEEF}) begin n_fail++; $display("FAIL st_data%0d: got %h/%h expected 00100/deadbeef", i, d_req_addr, d_req_wdata); end
    end
    step();
    d_req_ready = 0;
    @(negedge clock);
    n_cmp++; if ({d_req_valid, mem_stall, mem_write} !== 3'b000) begin n_fail++; $display("FAIL st_done: got valid/stall/wb %b expected 000", {d_req_valid, mem_stall, mem_write}); end
    step();
    idle_in();
    @(negedge clock);
    n_cmp++; if ({d_req_valid, mem_stall, mem_write} !== 3'b000) begin n_fail++; $display("FAIL st_after: got valid/stall/wb %b expected 000", {d_req_valid, mem_stall, mem_write}); end
    step();
  endtask
  task automatic test_load();
    mem_load = 1; mem_regWrite = 1; mem_rd = 7; mem_ALU_result = 32'h40;
    @(negedge clock);
    n_cmp++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL ld_idle_stall: got %b expected 1", mem_stall); end
    step();
    d_req_ready = 1;
    @(negedge clock);
    n_cmp++; if ({d_req_valid, d_req_write, mem_stall, d_req_addr} !== {3'b101, 20'h00040}) begin n_fail++; $display("FAIL ld_req: got valid/write/stall %b addr %h expected 101 00040", {d_req_valid, d_req_write, mem_stall}, d_req_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      d_req_ready = 0;
      d_resp_valid = (i == 2); d_resp_data = (i == 2) ? 32'hCAFEF00D : 32'h0;
      @(negedge clock);
      n_cmp++; if ({mem_stall, d_req_valid, mem_write} !== 3'b100) begin n_fail++; $display("FAIL ld_wait%0d: got stall/valid/wb %b expected 100", i, {mem_stall, d_req_valid, mem_write}); end
    end
    step();
    d_resp_valid = 0; d_resp_data = 0;
    @(negedge clock);
    n_cmp++; if ({mem_write, mem_write_reg, mem_write_data} !== {1'b1, 5'd7, 32'hCAFEF00D}) begin n_fail++; $display("FAIL ld_wb: got %b/%0d/%h expected 1/7/cafef00d", mem_write, mem_write_reg, mem_write_data); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL ld_done_stall: got %b expected 0", mem_stall); end
    step();
    idle_in();
    @(negedge clock);
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL ld_pulse: got %b expected 0", mem_write); end
    step();
  endtask
  task automatic test_back_to_back();
    mem_load = 1; mem_regWrite = 1; mem_rd = 4; mem_ALU_result = 32'h80;
    step();
    d_req_ready = 1;
    @(negedge clock);
    n_cmp++; if (d_req_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_req: got %b expected 1", d_req_valid); end
    step();
    d_req_ready = 0; d_resp_valid = 1; d_resp_data = 32'h11112222;
    step();
    d_resp_valid = 0; d_resp_data = 0;
    @(negedge clock);
    n_cmp++; if ({mem_write, mem_write_reg, mem_write_data, mem_stall} !== {1'b1, 5'd4, 32'h11112222, 1'b0}) begin n_fail++; $display("FAIL b2b_ld: got %b/%0d/%h stall %b expected 1/4/11112222 stall 0", mem_write, mem_write_reg, mem_write_data, mem_stall); end
    step();
    mem_load = 0; mem_regWrite = 1; mem_rd = 3; mem_ALU_result = 32'h9;
    @(negedge clock);
    n_cmp++; if ({mem_stall, d_req_valid, mem_write} !== 3'b000) begin n_fail++; $display("FAIL b2b_idle: got stall/valid/wb %b expected 000", {mem_stall, d_req_valid, mem_write}); end
    step();
    idle_in();
    @(negedge clock);
    n_cmp++; if ({mem_write, mem_write_reg, mem_write_data, d_req_valid} !== {1'b1, 5'd3, 32'h9, 1'b0}) begin n_fail++; $display("FAIL b2b_alu: got %b/%0d/%h valid %b expected 1/3/00000009 valid 0", mem_write, mem_write_reg, mem_write_data, d_req_valid); end
    step();
  endtask
  task automatic test_spurious();
    d_resp_valid = 1; d_resp_data = 32'hBAD;
    step();
    @(negedge clock);
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL sp_idle: got %b expected 0", mem_write); end
    mem_load = 1; mem_regWrite = 1; mem_rd = 9; mem_ALU_result = 32'h10;
    step();
    @(negedge clock);
    n_cmp++; if ({d_req_valid, mem_write} !== 2'b10) begin n_fail++; $display("FAIL sp_req: got valid/wb %b expected 10", {d_req_valid, mem_write}); end
    step();
    d_req_ready = 1;
    step();
    d_req_ready = 0; d_resp_valid = 0; d_resp_data = 0;
    @(negedge clock);
    n_cmp++; if ({mem_stall, d_req_valid, mem_write} !== 3'b100) begin n_fail++; $display("FAIL sp_wait: got stall/valid/wb %b expected 100", {mem_stall, d_req_valid, mem_write}); end
    step();
    d_resp_valid = 1; d_resp_data = 32'h600D;
    step();
    d_resp_valid = 0; d_resp_data = 0;
    @(negedge clock);
    n_cmp++; if ({mem_write, mem_write_reg, mem_write_data} !== {1'b1, 5'd9, 32'h600D}) begin n_fail++; $display("FAIL sp_wb: got %b/%0d/%h expected 1/9/0000600d", mem_write, mem_write_reg, mem_write_data); end
    step();
    idle_in();
    @(negedge clock);
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL sp_end: got %b expected 0", mem_write); end
    step();
  endtask
  initial begin
    idle_in();
    test_reset();
    test_passthrough();
    test_store();
    test_load();
    test_back_to_back();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
